serial_pattern_tx: RTL and testbench
====================================

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 Parameter: WIDTH, 8, maximum pattern length in bits (2..16).
REQ-002 Parameter: LW, $clog2(WIDTH+1), width of the len port.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 load  input  1  request to start a pattern; sampled only in IDLE.
REQ-006 data_in  input  WIDTH  pattern; transmitted MSB-first starting at bit len-1.
REQ-007 len  input  LW  bits to send; 0 or >WIDTH shall be treated as WIDTH.
REQ-008 repeat_en  input  1  when 1 at the last bit, the pattern restarts with no gap.
REQ-009 stop  input  1  abort; sampled in SEND.
REQ-010 x  output  1  serial bit stream; feeds the downstream sequence detector x input.
REQ-011 x_valid  output  1  high exactly on cycles where x carries a pattern bit.
REQ-012 busy  output  1  high in SEND and DONE.
REQ-013 done  output  1  one-cycle pulse after a non-repeating pattern completes.
REQ-014 bit_idx  output  LW  index of the bit currently on x; 0 when not in SEND.

Function
REQ-015 FSM states: IDLE, SEND, DONE; all outputs registered.
REQ-016 IDLE, load=1 at edge: data_in and effective len are captured into shadow registers; state -> SEND; on that edge x=data_in[len-1], x_valid=1, bit_idx=len-1.
REQ-017 IDLE, load=0: stay; x=0, x_valid=0, done=0, bit_idx=0.
REQ-018 SEND, bit_idx>0, stop=0: bit_idx decrements by 1 per cycle; x=shadow[bit_idx]; one bit per clock, no gaps.
REQ-019 SEND, bit_idx=0, stop=0, repeat_en=1: next cycle x=shadow[len-1], bit_idx=len-1; stay in SEND.
REQ-020 SEND, bit_idx=0, stop=0, repeat_en=0: -> DONE; next cycle x=0, x_valid=0, done=1.
REQ-021 DONE: lasts exactly one cycle, then -> IDLE; done returns to 0.
REQ-022 load during SEND or DONE is ignored; data_in/len changes during SEND do not affect the pattern in flight.
REQ-023 stop=1 in SEND, at any bit including the last: -> IDLE next cycle; x=0, x_valid=0, bit_idx=0, no done pulse; stop overrides repeat_en.
REQ-024 stop in IDLE or DONE has no effect; load and stop together in IDLE: load wins.
REQ-025 Latency: first bit on x 1 cycle after the load edge; done asserted len+1 cycles after the load edge.
REQ-026 len=1: a single bit is sent, then DONE.

Reset
REQ-027 rst=1 forces state IDLE immediately, without waiting for a clock edge: x=0, x_valid=0, busy=0, done=0, bit_idx=0; shadow registers cleared.
REQ-028 Reset mid-pattern aborts without a done pulse; after deassertion the block waits in IDLE for a new load.

Verification
REQ-029 load, data_in=8'b0000_1001, len=4, repeat_en=0 -> x=1,0,0,1 on 4 consecutive cycles, x_valid high on those cycles, done=1 on cycle 5 after load, busy low on cycle 6.
REQ-030 data_in=8'b0100_1010, len=7 -> x=1,0,0,1,0,1,0; wired to the sequence detector, its y matches the result of driving the same bits directly.
REQ-031 len=3, data_in=3'b101, repeat_en=1 for 9 cycles -> x=1,0,1,1,0,1,1,0,1 with no gap; repeat_en dropped during the last repetition -> a single done pulse.
REQ-032 stop asserted on bit_idx=2 of a len=8 pattern -> next cycle x_valid=0, busy=0, no done pulse; load during SEND is shown to be ignored.
REQ-033 rst pulsed between clock edges mid-pattern -> outputs zero before the next edge; load after release behaves as in REQ-029.
REQ-034 len=0 and len=15 with data_in=8'hA5 -> the full 8 bits 1,0,1,0,0,1,0,1 are sent.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first on o_x,
// with optional seamless repetition, abort, and a one-cycle done pulse.
module serial_pattern_tx #(
   parameter int WIDTH = 8,
   parameter int LW    = $clog2(WIDTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data_in,
   input  logic [LW-1:0]    i_len,
   input  logic             i_repeat_en,
   input  logic             i_stop,
   output logic             o_x,
   output logic             o_x_valid,
   output logic             o_busy,
   output logic             o_done,
   output logic [LW-1:0]    o_bit_idx
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

   localparam logic [LW-1:0] L_ONE   = LW'(1);
   localparam logic [LW-1:0] L_WIDTH = LW'(WIDTH);

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_shadow, w_shadow;
   logic [LW-1:0]    r_len, w_len;
   logic [LW-1:0]    r_bit_idx, w_bit_idx;
   logic             r_x, r_x_valid, r_busy, r_done;
   logic             w_x, w_x_valid, w_busy, w_done;
   logic [LW-1:0]    w_len_eff;
   logic             w_last;
   logic [WIDTH-1:0] w_sel_src, w_shift;
   logic [LW-1:0]    w_sel_idx;

   // Out-of-range lengths fall back to the full register width.
   assign w_len_eff = (i_len == '0 || i_len > L_WIDTH) ? L_WIDTH : i_len;
   assign w_last    = (r_bit_idx == '0);

   // Bit select by shift keeps the index width independent of WIDTH.
   assign w_shift = w_sel_src >> w_sel_idx;
   assign w_x     = w_x_valid & w_shift[0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_load) w_next = S_SEND;
         S_SEND: begin
            if (i_stop)                     w_next = S_IDLE;
            else if (w_last && !i_repeat_en) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_shadow  = r_shadow;
      w_len     = r_len;
      w_bit_idx = '0;
      w_x_valid = 1'b0;
      w_done    = 1'b0;
      w_sel_src = r_shadow;
      w_sel_idx = '0;
      w_busy    = (w_next != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (i_load) begin
               w_shadow  = i_data_in;
               w_len     = w_len_eff;
               w_sel_src = i_data_in;
               w_sel_idx = w_len_eff - L_ONE;
               w_bit_idx = w_len_eff - L_ONE;
               w_x_valid = 1'b1;
            end
         end
         S_SEND: begin
            // Stop wins over both the next bit and a pending repeat.
            if (!i_stop) begin
               if (!w_last) begin
                  w_sel_idx = r_bit_idx - L_ONE;
                  w_bit_idx = r_bit_idx - L_ONE;
                  w_x_valid = 1'b1;
               end else if (i_repeat_en) begin
                  w_sel_idx = r_len - L_ONE;
                  w_bit_idx = r_len - L_ONE;
                  w_x_valid = 1'b1;
               end else begin
                  w_done = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_shadow  <= '0;
         r_len     <= '0;
         r_bit_idx <= '0;
         r_x       <= 1'b0;
         r_x_valid <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_shadow  <= w_shadow;
         r_len     <= w_len;
         r_bit_idx <= w_bit_idx;
         r_x       <= w_x;
         r_x_valid <= w_x_valid;
         r_busy    <= w_busy;
         r_done    <= w_done;
      end
   end

   assign o_x       = r_x;
   assign o_x_valid = r_x_valid;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_bit_idx = r_bit_idx;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: expected bit/done events are queued at
// load time and a negedge monitor pops and compares them as the DUT emits them.
module tb_serial_pattern_tx;

   localparam int WIDTH = 8;
   localparam int LW    = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             load = 1'b0, rep = 1'b0, stop = 1'b0;
   logic [WIDTH-1:0] data = '0;
   logic [LW-1:0]    len = '0;
   logic             x, xv, busy, done;
   logic [LW-1:0]    bidx;

   typedef struct {
      bit            is_done;
      bit            x;
      logic [LW-1:0] idx;
   } ev_t;

   ev_t sb[$];
   ev_t e_mon;
   int  n_cmp = 0;
   int  n_bad = 0;

   serial_pattern_tx #(.WIDTH(WIDTH), .LW(LW)) dut (
      .i_clk(clk), .i_rst(rst), .i_load(load), .i_data_in(data), .i_len(len),
      .i_repeat_en(rep), .i_stop(stop), .o_x(x), .o_x_valid(xv), .o_busy(busy),
      .o_done(done), .o_bit_idx(bidx)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitor: every cycle with x_valid or done must match the next queued event.
   always @(negedge clk) begin
      if (xv || done) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output: x_valid=%0b done=%0b x=%0b bit_idx=%0d, required no output",
                     xv, done, x, bidx);
         end else begin
            e_mon = sb.pop_front();
            if (e_mon.is_done) begin
               if (!(done && !xv)) begin
                  n_bad++;
                  $display("FAIL done_event: done=%0b x_valid=%0b, required done=1 x_valid=0", done, xv);
               end
            end else if (!(xv && !done && x == e_mon.x && bidx == e_mon.idx)) begin
               n_bad++;
               $display("FAIL bit_event: x=%0b bit_idx=%0d x_valid=%0b done=%0b, required x=%0b bit_idx=%0d",
                        x, bidx, xv, done, e_mon.x, e_mon.idx);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue bits d[n-1]..d[lo], reps times, optionally followed by a done event.
   task automatic push_pat(input logic [WIDTH-1:0] d, input int n, input int reps,
                           input int lo, input bit with_done);
      for (int r = 0; r < reps; r++)
         for (int i = n - 1; i >= lo; i--)
            sb.push_back('{1'b0, d[i], LW'(i)});
      if (with_done) sb.push_back('{1'b1, 1'b0, '0});
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (busy && k < 40) begin
         tick();
         k++;
      end
      chk(nm, busy, 0);
   endtask

   task automatic run_basic(input string nm);
      load = 1; data = 8'b0000_1001; len = 4; rep = 0;
      push_pat(data, 4, 1, 0, 1);
      tick();
      load = 0;
      chk({nm, "_busy_c1"}, busy, 1);
      chk({nm, "_bidx_c1"}, bidx, 3);
      repeat (4) tick();
      chk({nm, "_done_c5"}, done, 1);
      chk({nm, "_busy_c5"}, busy, 1);
      tick();
      chk({nm, "_busy_c6"}, busy, 0);
      chk({nm, "_done_c6"}, done, 0);
   endtask

   initial begin
      // Reset state is asynchronous: visible before any clock edge.
      #3;
      chk("rst_x", x, 0);
      chk("rst_xv", xv, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bidx", bidx, 0);
      tick(); tick();
      rst = 0;
      tick();

      // Basic len=4 pattern with exact latency checks.
      run_basic("basic");

      // len=7; load and data/len changes during SEND are ignored.
      load = 1; data = 8'b0100_1010; len = 7; rep = 0;
      push_pat(data, 7, 1, 0, 1);
      tick();
      chk("len7_bidx", bidx, 6);
      data = 8'hFF; len = 2;
      repeat (3) tick();
      load = 0;
      wait_idle("len7_idle");

      // len=3 repeating; repeat dropped during the third pass.
      load = 1; data = 8'b0000_0101; len = 3; rep = 1;
      push_pat(data, 3, 3, 0, 1);
      tick();
      load = 0;
      repeat (6) tick();
      rep = 0;
      wait_idle("rep_idle");

      // Stop at bit_idx=2 of len=8, with load held during SEND.
      load = 1; data = 8'hC3; len = 8; rep = 0;
      push_pat(data, 8, 1, 2, 0);
      tick();
      data = 8'h00;
      repeat (5) tick();
      chk("stop_bidx_before", bidx, 2);
      load = 0; stop = 1;
      tick();
      chk("stop_xv", xv, 0);
      chk("stop_busy", busy, 0);
      chk("stop_bidx", bidx, 0);
      chk("stop_done", done, 0);
      stop = 0;
      tick();
      chk("stop_no_done", done, 0);

      // Stop on the last bit overrides repeat_en.
      load = 1; data = 8'h01; len = 2; rep = 1;
      push_pat(data, 2, 1, 0, 0);
      tick();
      load = 0;
      tick();
      stop = 1;
      tick();
      chk("stoplast_xv", xv, 0);
      chk("stoplast_busy", busy, 0);
      stop = 0; rep = 0;
      tick();

      // load and stop together in IDLE: load wins.
      load = 1; stop = 1; data = 8'b0000_0010; len = 2;
      push_pat(data, 2, 1, 0, 1);
      tick();
      load = 0; stop = 0;
      chk("ldstop_busy", busy, 1);
      wait_idle("ldstop_idle");

      // len=1 single bit.
      load = 1; data = 8'h01; len = 1;
      push_pat(data, 1, 1, 0, 1);
      tick();
      load = 0;
      chk("len1_bidx", bidx, 0);
      wait_idle("len1_idle");

      // len=0 and len=15 both send all 8 bits.
      load = 1; data = 8'hA5; len = 0;
      push_pat(data, 8, 1, 0, 1);
      tick();
      load = 0;
      chk("len0_bidx", bidx, 7);
      wait_idle("len0_idle");
      load = 1; data = 8'hA5; len = 15;
      push_pat(data, 8, 1, 0, 1);
      tick();
      load = 0;
      chk("len15_bidx", bidx, 7);
      wait_idle("len15_idle");

      // Asynchronous reset mid-pattern, between clock edges.
      load = 1; data = 8'b0000_1001; len = 4;
      push_pat(data, 4, 1, 0, 1);
      tick();
      load = 0;
      tick();
      #2 rst = 1;
      #1;
      chk("arst_x", x, 0);
      chk("arst_xv", xv, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_bidx", bidx, 0);
      rst = 0;
      sb.delete();
      repeat (3) tick();
      chk("arst_no_done", done, 0);
      run_basic("after_rst");

      tick();
      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
